// File: rtl/mealy_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mealy_det_pkg
// Description : Elaboration-time helpers for the Mealy pattern detector.
//               The functions compute the KMP transition function of a
//               constant pattern so the FSM can be built as a constant
//               lookup table with no runtime pattern storage.
//               Pattern bit i (0 = first received) is pattern[len-1-i].
// Revision    : 1.0 - initial release
// ============================================================================
package mealy_det_pkg;

  // Width of the matched-prefix state for an n-bit pattern (at least 1 bit).
  function automatic int state_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Next state from S_k on input bit b: the longest pattern prefix (strictly
  // shorter than the whole pattern) that is a suffix of the accepted prefix
  // of length k followed by b. On a completing bit this yields f(N).
  function automatic int kmp_next(input logic [31:0] pattern, input int len,
                                  input int k, input logic b);
    int   best;
    int   pos;
    logic ok;
    logic sbit;
    best = 0;
    for (int j = 1; j <= k + 1; j++) begin
      if (j < len) begin
        ok = 1'b1;
        for (int i = 0; i < j; i++) begin
          pos  = k + 1 - j + i;
          sbit = (pos == k) ? b : pattern[len-1-pos];
          if (sbit != pattern[len-1-i]) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int kmp_fail(input logic [31:0] pattern, input int len);
    return kmp_next(pattern, len, len - 1, pattern[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Ports       : clock  - rising-edge clock
//               reset  - asynchronous active-high reset (count -> 0)
//               clear  - synchronous clear, takes priority over inc
//               inc    - add one on this edge unless already at maximum
//               count  - current value, sticks at 2^W-1
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] C_MAX = '1;

  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mealy_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : mealy_pattern_detector
// Description : Serial Mealy pattern detector with KMP fallback, qualified
//               input, overlap / non-overlap modes, synchronous clear and a
//               saturating match counter.
// Ports       : clock       - rising-edge clock
//               reset       - asynchronous active-high reset
//               x_in        - serial data bit (first pattern bit = MSB)
//               x_valid     - x_in is accepted only when high
//               clear       - synchronous clear of state and counter
//               y_out       - same-cycle match (current bit completes pattern)
//               match_count - saturating number of matches
//               state_out   - matched-prefix length (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_pattern_detector
  import mealy_det_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     OVERLAP     = 1,
  parameter int                     COUNT_W     = 8,
  parameter int                     STATE_W     = state_w(PATTERN_LEN)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               x_in,
  input  logic               x_valid,
  input  logic               clear,
  output logic               y_out,
  output logic [COUNT_W-1:0] match_count,
  output logic [STATE_W-1:0] state_out
);

  localparam int                 C_NUM_STATES = 2 ** STATE_W;
  localparam logic [31:0]        C_PAT32      = 32'(PATTERN);
  localparam logic [STATE_W-1:0] C_LAST       = STATE_W'(PATTERN_LEN - 1);
  localparam logic [STATE_W-1:0] C_FAIL       = STATE_W'(kmp_fail(C_PAT32, PATTERN_LEN));
  localparam logic [STATE_W-1:0] C_AFTER_HIT  = (OVERLAP != 0) ? C_FAIL : '0;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_next;
  logic               w_match;

  // Constant transition table indexed by {state, x_in}. Encodings above
  // S_(N-1) are unreachable and simply fall back to S_0.
  logic [STATE_W-1:0] w_next_tbl [2*C_NUM_STATES];

  for (genvar gk = 0; gk < C_NUM_STATES; gk++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      if (gk >= PATTERN_LEN) begin : g_unused
        assign w_next_tbl[gk*2+gb] = '0;
      end else if ((gk == PATTERN_LEN - 1) && (1'(gb) == PATTERN[0])) begin : g_hit
        assign w_next_tbl[gk*2+gb] = C_AFTER_HIT;
      end else begin : g_step
        assign w_next_tbl[gk*2+gb] = STATE_W'(kmp_next(C_PAT32, PATTERN_LEN, gk, 1'(gb)));
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear wins over a simultaneous valid bit; invalid cycles hold state.
  always_comb begin
    w_state_next = r_state;
    w_match      = 1'b0;
    if (clear) begin
      w_state_next = '0;
    end else if (x_valid) begin
      w_state_next = w_next_tbl[{r_state, x_in}];
      w_match      = (r_state == C_LAST) && (x_in == PATTERN[0]);
    end
  end

  // The counter is held in reset asynchronously, so only the output port
  // needs the reset gate.
  assign y_out     = w_match & ~reset;
  assign state_out = r_state;

  sat_counter #(
    .W (COUNT_W)
  ) u_sat_counter (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .inc   (w_match),
    .count (match_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_mealy_pattern_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_pattern_detector
// Description : Directed self-checking bench. Three detector instances share
//               the stimulus: 1011 overlapping, 1011 non-overlapping and a
//               one-bit pattern 0 with a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_pattern_detector;

  logic       clock;
  logic       reset;
  logic       x_in;
  logic       x_valid;
  logic       clear;

  logic       y_ov1, y_ov0, y_sat;
  logic [7:0] cnt_ov1, cnt_ov0;
  logic [1:0] cnt_sat;
  logic [1:0] st_ov1, st_ov0;
  logic       st_sat;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed expectations
  int st1_seq1 [7] = '{1, 2, 3, 1, 2, 3, 1};
  int st0_seq1 [7] = '{1, 2, 3, 0, 0, 1, 1};
  int st0_kmp  [6] = '{1, 2, 3, 2, 3, 0};
  int sat_cnt  [6] = '{1, 2, 3, 3, 3, 3};

  mealy_pattern_detector #(
    .PATTERN_LEN (4), .PATTERN (4'b1011), .OVERLAP (1), .COUNT_W (8)
  ) u_ov1 (
    .clock (clock), .reset (reset), .x_in (x_in), .x_valid (x_valid),
    .clear (clear), .y_out (y_ov1), .match_count (cnt_ov1), .state_out (st_ov1)
  );

  mealy_pattern_detector #(
    .PATTERN_LEN (4), .PATTERN (4'b1011), .OVERLAP (0), .COUNT_W (8)
  ) u_ov0 (
    .clock (clock), .reset (reset), .x_in (x_in), .x_valid (x_valid),
    .clear (clear), .y_out (y_ov0), .match_count (cnt_ov0), .state_out (st_ov0)
  );

  mealy_pattern_detector #(
    .PATTERN_LEN (1), .PATTERN (1'b0), .OVERLAP (1), .COUNT_W (2)
  ) u_sat (
    .clock (clock), .reset (reset), .x_in (x_in), .x_valid (x_valid),
    .clear (clear), .y_out (y_sat), .match_count (cnt_sat), .state_out (st_sat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs mid-cycle; combinational y_out is checked right after.
  task automatic drive(input logic b, input logic v, input logic clr);
    @(negedge clock);
    x_in    = b;
    x_valid = v;
    clear   = clr;
    #1;
  endtask

  // Let the next rising edge happen, then settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    clear = 1'b0;
  endtask

  initial begin
    logic [6:0] s1;
    logic [6:0] y1e;
    logic [6:0] y0e;
    logic [5:0] s2;
    logic [3:0] s3;

    reset = 1'b1; x_in = 1'b0; x_valid = 1'b0; clear = 1'b0;
    #2;
    // While in reset, a matching bit for the N=1 instance must not show.
    x_in = 1'b0; x_valid = 1'b1;
    #1;
    check("rst_y_sat", 32'(y_sat), 32'(0));
    check("rst_state", 32'(st_ov1), 32'(0));
    check("rst_count", 32'(cnt_ov1), 32'(0));
    x_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Overlap vs non-overlap on 1,0,1,1,0,1,1
    s1  = 7'b1011011;
    y1e = 7'b0001001;
    y0e = 7'b0001000;
    for (int i = 0; i < 7; i++) begin
      drive(s1[6-i], 1'b1, 1'b0);
      check("seq1_y_ov1", 32'(y_ov1), 32'(y1e[6-i]));
      check("seq1_y_ov0", 32'(y_ov0), 32'(y0e[6-i]));
      tick();
      check("seq1_st_ov1", 32'(st_ov1), 32'(st1_seq1[i]));
      check("seq1_st_ov0", 32'(st_ov0), 32'(st0_seq1[i]));
    end
    check("seq1_cnt_ov1", 32'(cnt_ov1), 32'(2));
    check("seq1_cnt_ov0", 32'(cnt_ov0), 32'(1));

    // KMP fallback on 1,0,1,0,1,1
    do_clear();
    check("clr_st", 32'(st_ov0), 32'(0));
    check("clr_cnt", 32'(cnt_ov1), 32'(0));
    s2 = 6'b101011;
    for (int i = 0; i < 6; i++) begin
      drive(s2[5-i], 1'b1, 1'b0);
      check("kmp_y_ov0", 32'(y_ov0), 32'((i == 5) ? 1 : 0));
      tick();
      check("kmp_st_ov0", 32'(st_ov0), 32'(st0_kmp[i]));
    end

    // Gaps: three invalid cycles (x_in held at 1) after every bit
    do_clear();
    s3 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      drive(s3[3-i], 1'b1, 1'b0);
      check("gap_y_valid", 32'(y_ov1), 32'((i == 3) ? 1 : 0));
      tick();
      for (int g = 0; g < 3; g++) begin
        drive(1'b1, 1'b0, 1'b0);
        check("gap_y_idle", 32'(y_ov1), 32'(0));
        tick();
      end
    end
    check("gap_cnt_ov1", 32'(cnt_ov1), 32'(1));
    check("gap_st_ov1", 32'(st_ov1), 32'(1));

    // Async reset pulse between edges after 1,0,1
    do_clear();
    for (int i = 0; i < 3; i++) begin
      drive(s3[3-i], 1'b1, 1'b0);
      tick();
    end
    check("prerst_st", 32'(st_ov1), 32'(3));
    @(negedge clock);
    x_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check("async_rst_st", 32'(st_ov1), 32'(0));
    #1 reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    check("postrst_y", 32'(y_ov1), 32'(0));
    tick();
    check("postrst_st", 32'(st_ov1), 32'(1));

    // From S1: 0,1,1 matches, then 0,1 reach S3; completing bit with clear
    drive(1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0);
    check("pre_clr_y", 32'(y_ov1), 32'(1));
    tick();
    check("pre_clr_cnt", 32'(cnt_ov1), 32'(1));
    drive(1'b0, 1'b1, 1'b0); tick();
    drive(1'b1, 1'b1, 1'b0); tick();
    check("pre_clr_st", 32'(st_ov1), 32'(3));
    drive(1'b1, 1'b1, 1'b1);
    check("clr_hit_y", 32'(y_ov1), 32'(0));
    tick();
    clear = 1'b0;
    check("clr_hit_cnt", 32'(cnt_ov1), 32'(0));
    check("clr_hit_st", 32'(st_ov1), 32'(0));

    // Saturation of the 2-bit counter, pattern "0"
    do_clear();
    check("sat_clr", 32'(cnt_sat), 32'(0));
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check("sat_y", 32'(y_sat), 32'(1));
      tick();
      check("sat_cnt", 32'(cnt_sat), 32'(sat_cnt[i]));
    end
    check("sat_st", 32'(st_sat), 32'(0));

    x_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
